axi_rd_responder: RTL and testbench
===================================

AXI_RD_RESPONDER -- requirements
Module: axi_rd_responder

Interface
REQ-001 SHALL have parameter ADDR_BITS, default 16, the address width.
REQ-002 SHALL have parameter TID_WIDTH, default 8, the transaction ID width.
REQ-003 SHALL have parameter BURST_LEN_WIDTH, default 8, the AXI len width (beats = len+1).
REQ-004 SHALL have parameter LOG_BLOCK_DATA_BYTES, default 0, where DATA_WIDTH = 8<<LOG_BLOCK_DATA_BYTES.
REQ-005 SHALL have parameter LOG_QUEUE_SIZE, default 2, giving a request queue depth of 2^LOG_QUEUE_SIZE.
REQ-006 SHALL have parameter DELAY_WIDTH, default 3, the width of the latency CR.
REQ-007 SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-008 SHALL have port resetN, input, 1 bit: asynchronous active-low reset.
REQ-009 SHALL have port s_ar_valid, input, 1 bit: read request valid.
REQ-010 SHALL have port s_ar_ready, output, 1 bit: read request accepted.
REQ-011 SHALL have port s_ar_len, input, BURST_LEN_WIDTH bits: burst length minus one.
REQ-012 SHALL have port s_ar_addr, input, ADDR_BITS bits: start byte address.
REQ-013 SHALL have port s_ar_id, input, TID_WIDTH bits: request ID.
REQ-014 SHALL have port m_r_valid, output, 1 bit: read data valid.
REQ-015 SHALL have port m_r_ready, input, 1 bit: downstream ready.
REQ-016 SHALL have port m_r_last, output, 1 bit: final beat of the burst.
REQ-017 SHALL have port m_r_data, output, DATA_WIDTH bits: beat data.
REQ-018 SHALL have port m_r_id, output, TID_WIDTH bits: echoed request ID.
REQ-019 SHALL have port crs_latency, input, DELAY_WIDTH bits: wait cycles before the first beat.
REQ-020 SHALL have port busy, output, 1 bit: high when the queue is non-empty or the FSM is not in IDLE.

Function
REQ-021 SHALL buffer requests {addr, len, id} in an in-order FIFO of depth 2^LOG_QUEUE_SIZE.
REQ-022 SHALL drive s_ar_ready = !full; a push occurs on s_ar_valid && s_ar_ready at a rising edge.
REQ-023 SHALL NOT bypass when full: a same-cycle pop while full does not raise s_ar_ready in that cycle.
REQ-024 SHALL implement an FSM with states IDLE, WAIT and BURST.
REQ-025 In IDLE with the FIFO non-empty, the FSM SHALL pop the head, latch addr/len/id, and sample crs_latency (L) at that edge.
REQ-026 The IDLE pop SHALL go to BURST if L==0; otherwise it SHALL go to WAIT with cnt=L.
REQ-027 WAIT SHALL decrement cnt each cycle and go to BURST on the edge where cnt==1.
REQ-028 A request accepted at edge T SHALL first show m_r_valid in the cycle after edge T+1+L when the FIFO and FSM were idle.
REQ-029 In BURST the block SHALL hold m_r_valid=1; data, id and last SHALL stay stable until m_r_valid && m_r_ready.
REQ-030 Beat k (0-based) SHALL carry m_r_data = low DATA_WIDTH bits of (addr + k*(1<<LOG_BLOCK_DATA_BYTES)), computed modulo 2^ADDR_BITS with wrap-around.
REQ-031 m_r_last SHALL be 1 exactly on beat k==len; len==0 gives a single beat with last=1.
REQ-032 On the handshake of the last beat, the FSM SHALL return to IDLE, leaving one idle cycle between bursts.
REQ-033 Beat counting SHALL use BURST_LEN_WIDTH+1 bits so that len = all-ones (256 beats) terminates correctly.
REQ-034 m_r_valid, m_r_last, m_r_data and m_r_id SHALL be registered outputs, with no combinational path from m_r_ready.
REQ-035 A change of crs_latency during WAIT or BURST SHALL affect only subsequently popped requests.

Reset
REQ-036 When resetN=0, the block SHALL asynchronously clear the FIFO pointers/count, set the FSM to IDLE, and clear cnt and the beat counter.
REQ-037 During reset, outputs SHALL be m_r_valid=0, m_r_last=0, m_r_data=0, m_r_id=0, busy=0 and s_ar_ready=0.
REQ-038 s_ar_ready SHALL rise in the first cycle after resetN deasserts.
REQ-039 Reset asserted mid-burst SHALL discard all queued and in-flight requests; no beat SHALL be emitted after release without a new request.

Verification
REQ-040 Scenario: L=0, addr=0x0EEF, len=0, id=5, m_r_ready=1 -> one beat one cycle after the pop, data=0xEF, id=5, last=1.
REQ-041 Scenario: L=3, addr=0x00FE, len=3, m_r_ready=1 -> data 0xFE,0xFF,0x00,0x01; last on the 4th beat; first valid 4 cycles after the pop.
REQ-042 Scenario: 5 back-to-back requests with m_r_ready=0 and depth 4 -> s_ar_ready low after 4 pushes plus 1 pop; no request lost; ids returned in order.
REQ-043 Scenario: m_r_ready toggled randomly during len=7 -> 8 beats; valid never drops and data is stable while stalled.
REQ-044 Scenario: addr=0xFFFF, len=1 -> data 0xFF then 0x00 (address wrap).
REQ-045 Scenario: resetN pulsed low during beat 2 of len=5 -> valid=0 immediately; after release busy=0 and no beats appear.

Source files
------------

// File: rtl/axi_rd_responder.sv
// AXI-style read responder: queues read requests, waits a configurable latency,
// then streams address-derived beat data back with in-order IDs.
module axi_rd_responder #(
    parameter int unsigned ADDR_BITS            = 16,
    parameter int unsigned TID_WIDTH            = 8,
    parameter int unsigned BURST_LEN_WIDTH      = 8,
    parameter int unsigned LOG_BLOCK_DATA_BYTES = 0,
    parameter int unsigned LOG_QUEUE_SIZE       = 2,
    parameter int unsigned DELAY_WIDTH          = 3,
    localparam int unsigned DATA_WIDTH          = 8 << LOG_BLOCK_DATA_BYTES
) (
    input  logic                       clk,
    input  logic                       resetN,
    input  logic                       s_ar_valid,
    output logic                       s_ar_ready,
    input  logic [BURST_LEN_WIDTH-1:0] s_ar_len,
    input  logic [ADDR_BITS-1:0]       s_ar_addr,
    input  logic [TID_WIDTH-1:0]       s_ar_id,
    output logic                       m_r_valid,
    input  logic                       m_r_ready,
    output logic                       m_r_last,
    output logic [DATA_WIDTH-1:0]      m_r_data,
    output logic [TID_WIDTH-1:0]       m_r_id,
    input  logic [DELAY_WIDTH-1:0]     crs_latency,
    output logic                       busy
);

    localparam int unsigned Depth  = 1 << LOG_QUEUE_SIZE;
    localparam int unsigned EntryW = ADDR_BITS + BURST_LEN_WIDTH + TID_WIDTH;
    localparam int unsigned ExtW   = (DATA_WIDTH > ADDR_BITS) ? DATA_WIDTH : ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] Step = ADDR_BITS'(1 << LOG_BLOCK_DATA_BYTES);

    typedef enum logic [1:0] {StIdle, StWait, StBurst} state_e;

    function automatic logic [DATA_WIDTH-1:0] beat_data(input logic [ADDR_BITS-1:0] a);
        logic [ExtW-1:0] ext;
        ext = ExtW'(a);
        return ext[DATA_WIDTH-1:0];
    endfunction

    // Request FIFO
    logic [EntryW-1:0]         mem_q [Depth];
    logic [LOG_QUEUE_SIZE-1:0] wr_ptr_q, rd_ptr_q;
    logic [LOG_QUEUE_SIZE:0]   count_q;
    logic                      full, empty, push, pop;
    logic [EntryW-1:0]         head;
    logic [ADDR_BITS-1:0]      head_addr;
    logic [BURST_LEN_WIDTH-1:0] head_len;
    logic [TID_WIDTH-1:0]      head_id;

    assign full       = (count_q == (LOG_QUEUE_SIZE + 1)'(Depth));
    assign empty      = (count_q == '0);
    assign s_ar_ready = resetN && !full;
    assign push       = s_ar_valid && s_ar_ready;
    assign head       = mem_q[rd_ptr_q];
    assign head_addr  = head[EntryW-1 -: ADDR_BITS];
    assign head_len   = head[TID_WIDTH +: BURST_LEN_WIDTH];
    assign head_id    = head[TID_WIDTH-1:0];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {s_ar_addr, s_ar_len, s_ar_id};
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            if (push && !pop)      count_q <= count_q + 1'b1;
            else if (!push && pop) count_q <= count_q - 1'b1;
        end
    end

    // Burst engine
    state_e                     state_q, state_d;
    logic [DELAY_WIDTH-1:0]     cnt_q, cnt_d;
    logic [BURST_LEN_WIDTH:0]   beat_q, beat_d;
    logic [ADDR_BITS-1:0]       addr_q, addr_d;
    logic [BURST_LEN_WIDTH-1:0] len_q, len_d;
    logic [TID_WIDTH-1:0]       id_q, id_d;
    logic [DATA_WIDTH-1:0]      data_q, data_d;
    logic                       last_q, last_d;

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) state_q <= StIdle;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (!empty) state_d = (crs_latency == '0) ? StBurst : StWait;
            StWait:  if (cnt_q == DELAY_WIDTH'(1)) state_d = StBurst;
            StBurst: if (m_r_ready && last_q) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pop    = 1'b0;
        cnt_d  = cnt_q;
        beat_d = beat_q;
        addr_d = addr_q;
        len_d  = len_q;
        id_d   = id_q;
        data_d = data_q;
        last_d = last_q;
        unique case (state_q)
            StIdle: begin
                if (!empty) begin
                    pop    = 1'b1;
                    cnt_d  = crs_latency;
                    beat_d = '0;
                    addr_d = head_addr;
                    len_d  = head_len;
                    id_d   = head_id;
                    data_d = beat_data(head_addr);
                    last_d = (head_len == '0);
                end
            end
            StWait: cnt_d = cnt_q - 1'b1;
            StBurst: begin
                // Next beat is prepared on the handshake so outputs stay registered
                if (m_r_ready && !last_q) begin
                    beat_d = beat_q + 1'b1;
                    addr_d = addr_q + Step;
                    data_d = beat_data(addr_d);
                    last_d = (beat_d == {1'b0, len_q});
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetN) begin
        if (!resetN) begin
            cnt_q  <= '0;
            beat_q <= '0;
            addr_q <= '0;
            len_q  <= '0;
            id_q   <= '0;
            data_q <= '0;
            last_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            beat_q <= beat_d;
            addr_q <= addr_d;
            len_q  <= len_d;
            id_q   <= id_d;
            data_q <= data_d;
            last_q <= last_d;
        end
    end

    assign m_r_valid = (state_q == StBurst);
    assign m_r_last  = last_q;
    assign m_r_data  = data_q;
    assign m_r_id    = id_q;
    assign busy      = !empty || (state_q != StIdle);

endmodule

// File: tb/tb_axi_rd_responder.sv
// Bench for axi_rd_responder: table of read requests checked through a beat scoreboard,
// plus hand-written backpressure/full-queue and mid-burst reset sequences.
module tb_axi_rd_responder;

    logic        clk;
    logic        resetN;
    logic        s_ar_valid;
    logic        s_ar_ready;
    logic [7:0]  s_ar_len;
    logic [15:0] s_ar_addr;
    logic [7:0]  s_ar_id;
    logic        m_r_valid;
    logic        m_r_ready;
    logic        m_r_last;
    logic [7:0]  m_r_data;
    logic [7:0]  m_r_id;
    logic [2:0]  crs_latency;
    logic        busy;

    axi_rd_responder dut (
        .clk         (clk),
        .resetN      (resetN),
        .s_ar_valid  (s_ar_valid),
        .s_ar_ready  (s_ar_ready),
        .s_ar_len    (s_ar_len),
        .s_ar_addr   (s_ar_addr),
        .s_ar_id     (s_ar_id),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_last    (m_r_last),
        .m_r_data    (m_r_data),
        .m_r_id      (m_r_id),
        .crs_latency (crs_latency),
        .busy        (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        logic [15:0] addr;
        logic [7:0]  len;
        logic [7:0]  id;
        logic [2:0]  lat;
        int          rmode;
        logic [7:0]  first;
        int          edges;
    } vec_t;

    typedef struct {
        logic [7:0] data;
        logic [7:0] id;
        logic       last;
    } exp_t;

    vec_t vecs[6];
    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;
    int   rdy_mode = 0;
    int   beats_seen = 0;

    logic       prev_stall = 1'b0;
    logic [7:0] pd, pi;
    logic       pl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic mon_step();
        exp_t e;
        if (!resetN) begin
            prev_stall = 1'b0;
            return;
        end
        if (prev_stall) begin
            chk("stall_valid", {31'd0, m_r_valid}, 32'd1);
            chk("stall_data", {m_r_id, m_r_data, 7'd0, m_r_last}, {pi, pd, 7'd0, pl});
        end
        if (m_r_valid && m_r_ready) begin
            beats_seen++;
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h id %0h expected no beat",
                         m_r_data, m_r_id);
            end else begin
                e = sb.pop_front();
                chk("beat", {m_r_id, m_r_data, 7'd0, m_r_last}, {e.id, e.data, 7'd0, e.last});
            end
        end
        prev_stall = m_r_valid && !m_r_ready;
        pd = m_r_data;
        pi = m_r_id;
        pl = m_r_last;
    endtask

    task automatic send(input logic [15:0] addr, input logic [7:0] len, input logic [7:0] id);
        int   g;
        exp_t e;
        logic [15:0] a;
        s_ar_valid = 1'b1;
        s_ar_addr  = addr;
        s_ar_len   = len;
        s_ar_id    = id;
        g = 0;
        while (!s_ar_ready && g < 2000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 2000) chk("ar_accept_timeout", 32'd1, 32'd0);
        @(posedge clk); #1;
        s_ar_valid = 1'b0;
        for (int k = 0; k <= int'(len); k++) begin
            a = addr + 16'(k);
            e.data = a[7:0];
            e.id   = id;
            e.last = (k == int'(len));
            sb.push_back(e);
        end
    endtask

    task automatic drain();
        int g = 0;
        while ((sb.size() != 0 || busy) && g < 3000) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 3000) chk("drain_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        int n;
        int b0;
        logic seen;

        vecs[0] = '{16'h0EEF, 8'd0,   8'h05, 3'd0, 0, 8'hEF, 1};
        vecs[1] = '{16'h00FE, 8'd3,   8'h01, 3'd3, 0, 8'hFE, 4};
        vecs[2] = '{16'hFFFF, 8'd1,   8'h02, 3'd1, 1, 8'hFF, 2};
        vecs[3] = '{16'h1234, 8'd7,   8'h03, 3'd2, 1, 8'h34, 3};
        vecs[4] = '{16'h0010, 8'd255, 8'h04, 3'd7, 0, 8'h10, 8};
        vecs[5] = '{16'hABCD, 8'd2,   8'hA5, 3'd5, 1, 8'hCD, 6};

        resetN      = 1'b0;
        s_ar_valid  = 1'b0;
        s_ar_len    = '0;
        s_ar_addr   = '0;
        s_ar_id     = '0;
        m_r_ready   = 1'b0;
        crs_latency = '0;

        fork
            forever begin
                @(negedge clk);
                mon_step();
            end
            forever begin
                @(posedge clk); #1;
                case (rdy_mode)
                    0:       m_r_ready = 1'b1;
                    1:       m_r_ready = 1'($urandom_range(0, 1));
                    default: m_r_ready = 1'b0;
                endcase
            end
        join_none

        #3;
        chk("rst_valid", {31'd0, m_r_valid}, 32'd0);
        chk("rst_last", {31'd0, m_r_last}, 32'd0);
        chk("rst_data_id", {16'd0, m_r_id, m_r_data}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        chk("rst_ar_ready", {31'd0, s_ar_ready}, 32'd0);
        #19 resetN = 1'b1;
        #1;
        chk("post_rst_ar_ready", {31'd0, s_ar_ready}, 32'd1);
        chk("post_rst_busy", {31'd0, busy}, 32'd0);
        @(posedge clk); #1;

        // Table-driven requests: latency, first beat and full beat stream
        foreach (vecs[i]) begin
            rdy_mode    = vecs[i].rmode;
            crs_latency = vecs[i].lat;
            send(vecs[i].addr, vecs[i].len, vecs[i].id);
            n = 0;
            while (!m_r_valid && n < 50) begin
                @(posedge clk); #1;
                n++;
                // Changing the latency after the pop must not affect this request
                if (n == 2) crs_latency = ~vecs[i].lat;
            end
            chk("first_valid_edges", n, vecs[i].edges);
            chk("first_data_id", {16'd0, m_r_id, m_r_data}, {16'd0, vecs[i].id, vecs[i].first});
            drain();
            chk("idle_after_burst", {31'd0, busy}, 32'd0);
        end

        // Full queue under backpressure: one pop plus four queued
        rdy_mode    = 2;
        crs_latency = '0;
        for (int k = 0; k < 5; k++) send(16'h0100 + 16'(k), 8'd0, 8'd10 + 8'(k));
        chk("full_ar_ready", {31'd0, s_ar_ready}, 32'd0);
        chk("full_busy", {31'd0, busy}, 32'd1);
        repeat (3) begin
            @(posedge clk); #1;
        end
        chk("full_ar_ready_hold", {31'd0, s_ar_ready}, 32'd0);
        chk("full_valid_held", {31'd0, m_r_valid}, 32'd1);
        rdy_mode = 0;
        send(16'h0200, 8'd1, 8'd15);
        drain();

        // Reset during beat 2 of a 6-beat burst
        rdy_mode    = 0;
        crs_latency = '0;
        b0 = beats_seen;
        send(16'h0040, 8'd5, 8'h33);
        n = 0;
        while (beats_seen < b0 + 2 && n < 100) begin
            @(posedge clk);
            n++;
        end
        if (n >= 100) chk("reset_setup_timeout", 32'd1, 32'd0);
        #2 resetN = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, m_r_valid}, 32'd0);
        chk("midrst_outs", {15'd0, busy, m_r_id, m_r_data}, 32'd0);
        sb.delete();
        b0 = beats_seen;
        @(negedge clk);
        #2 resetN = 1'b1;
        seen = 1'b0;
        repeat (20) begin
            @(posedge clk); #1;
            if (m_r_valid) seen = 1'b1;
        end
        chk("after_rst_no_valid", {31'd0, seen}, 32'd0);
        chk("after_rst_busy", {31'd0, busy}, 32'd0);
        chk("after_rst_beats", beats_seen, b0);
        chk("after_rst_ar_ready", {31'd0, s_ar_ready}, 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
